// File: rtl/commit_trace_serializer.sv
// Commit trace serializer: buffers 2-wide retirements in a FIFO and emits them one per handshake with a sequence number.
// Optional PC continuity checker: define COMMIT_TRACE_PC_CHECK_EN. Only IssueWidth = 2 is supported.
module commit_trace_serializer #(
    parameter int XLEN       = 32,
    parameter int IssueWidth = 2,
    parameter int DEPTH      = 8,
    parameter int SEQW       = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [IssueWidth-1:0]                update_i,
    input  logic [IssueWidth-1:0][XLEN-1:0]      pc_i,
    input  logic [IssueWidth-1:0][XLEN-1:0]      instr_i,
    input  logic [IssueWidth-1:0][4:0]           reg_addr_i,
    input  logic [IssueWidth-1:0][XLEN-1:0]      reg_data_i,
    input  logic [IssueWidth-1:0][XLEN-1:0]      mem_addr_i,
    input  logic [IssueWidth-1:0][XLEN-1:0]      mem_data_i,
    input  logic [IssueWidth-1:0]                mem_wrt_i,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [SEQW-1:0]                      out_seq_o,
    output logic [XLEN-1:0]                      out_pc_o,
    output logic [XLEN-1:0]                      out_instr_o,
    output logic [4:0]                           out_reg_addr_o,
    output logic [XLEN-1:0]                      out_reg_data_o,
    output logic [XLEN-1:0]                      out_mem_addr_o,
    output logic [XLEN-1:0]                      out_mem_data_o,
    output logic                                 out_mem_wrt_o,
    output logic                                 out_reg_wr_o,
    output logic [$clog2(DEPTH):0]               count_o,
    output logic                                 overflow_o,
`ifdef COMMIT_TRACE_PC_CHECK_EN
    output logic                                 pc_err_o,
    output logic [XLEN-1:0]                      err_pc_o,
`endif
    output logic [15:0]                          drop_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [4:0]      regAddr;
        logic [XLEN-1:0] regData;
        logic [XLEN-1:0] memAddr;
        logic [XLEN-1:0] memData;
        logic            memWrt;
        logic            regWr;
    } payload_t;

    typedef struct packed {
        logic [SEQW-1:0] seq;
        payload_t        pl;
    } entry_t;

    payload_t laneEnt [IssueWidth];
    entry_t   slotEnt [2];
    entry_t   fifoMem [DEPTH];
    entry_t   head;

    logic [AW-1:0]   rdPtr, wrPtr, wrPtrNext1;
    logic [CW-1:0]   count, freeSlots;
    logic [SEQW-1:0] nextSeq;
    logic [1:0]      nCand, nAcc, nDrop;
    logic            pop, overflow;
    logic [15:0]     dropCnt;
    logic [16:0]     dropSum;

    for (genvar g = 0; g < IssueWidth; g++) begin : gLane
        assign laneEnt[g] = '{pc: pc_i[g], instr: instr_i[g], regAddr: reg_addr_i[g],
                              regData: reg_data_i[g], memAddr: mem_addr_i[g],
                              memData: mem_data_i[g], memWrt: mem_wrt_i[g],
                              regWr: (reg_addr_i[g] != 5'd0)};
    end

    // Space is judged on start-of-cycle occupancy; a same-cycle pop never frees room.
    always_comb begin
        freeSlots  = CW'(DEPTH) - count;
        nCand      = {1'b0, update_i[0]} + {1'b0, update_i[1]};
        nAcc       = (CW'(nCand) <= freeSlots) ? nCand : freeSlots[1:0];
        nDrop      = nCand - nAcc;
        pop        = (count != '0) && out_ready_i;
        wrPtrNext1 = wrPtr + AW'(1);
        slotEnt[0] = '{seq: nextSeq, pl: (update_i[0] ? laneEnt[0] : laneEnt[1])};
        slotEnt[1] = '{seq: nextSeq + SEQW'(1), pl: laneEnt[1]};
        dropSum    = {1'b0, dropCnt} + 17'(nDrop);
    end

    always_ff @(posedge clk) begin
        if (nAcc != 2'd0) fifoMem[wrPtr] <= slotEnt[0];
        if (nAcc == 2'd2) fifoMem[wrPtrNext1] <= slotEnt[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
            nextSeq  <= '0;
            overflow <= 1'b0;
            dropCnt  <= '0;
        end else begin
            wrPtr    <= wrPtr + AW'(nAcc);
            if (pop) rdPtr <= rdPtr + AW'(1);
            count    <= count + CW'(nAcc) - CW'(pop);
            nextSeq  <= nextSeq + SEQW'(nAcc);
            overflow <= overflow | (nDrop != 2'd0);
            dropCnt  <= dropSum[16] ? 16'hFFFF : dropSum[15:0];
        end
    end

    // Head fields are forced to zero while the FIFO is empty.
    always_comb begin
        head           = (count != '0) ? fifoMem[rdPtr] : '0;
        out_valid_o    = (count != '0);
        out_seq_o      = head.seq;
        out_pc_o       = head.pl.pc;
        out_instr_o    = head.pl.instr;
        out_reg_addr_o = head.pl.regAddr;
        out_reg_data_o = head.pl.regData;
        out_mem_addr_o = head.pl.memAddr;
        out_mem_data_o = head.pl.memData;
        out_mem_wrt_o  = head.pl.memWrt;
        out_reg_wr_o   = head.pl.regWr;
        count_o        = count;
        overflow_o     = overflow;
        drop_cnt_o     = dropCnt;
    end

`ifdef COMMIT_TRACE_PC_CHECK_EN
    logic            pcErr, havePrev, chkValid, errNow;
    logic [XLEN-1:0] errPc, expPc, chkExp, errPcNow;
    logic [6:0]      opc;

    // Walk accepted slots in program order; a jump/branch or reset leaves the next pc unconstrained.
    always_comb begin
        chkValid = havePrev;
        chkExp   = expPc;
        errNow   = 1'b0;
        errPcNow = '0;
        opc      = '0;
        for (int s = 0; s < 2; s++) begin
            if (s < int'(nAcc)) begin
                if (chkValid && (slotEnt[s].pl.pc != chkExp) && !errNow) begin
                    errNow   = 1'b1;
                    errPcNow = slotEnt[s].pl.pc;
                end
                opc      = slotEnt[s].pl.instr[6:0];
                chkExp   = slotEnt[s].pl.pc + XLEN'(4);
                chkValid = !(opc == 7'b1101111 || opc == 7'b1100111 || opc == 7'b1100011);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcErr    <= 1'b0;
            errPc    <= '0;
            havePrev <= 1'b0;
            expPc    <= '0;
        end else begin
            havePrev <= chkValid;
            expPc    <= chkExp;
            if (!pcErr && errNow) begin
                pcErr <= 1'b1;
                errPc <= errPcNow;
            end
        end
    end

    assign pc_err_o = pcErr;
    assign err_pc_o = errPc;
`endif

endmodule

// File: tb/tb_commit_trace_serializer.sv
// Directed bench for commit_trace_serializer; PC-check steps run when COMMIT_TRACE_PC_CHECK_EN is defined.
module tb_commit_trace_serializer;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        update_i;
    logic [1:0][31:0]  pc_i, instr_i, reg_data_i, mem_addr_i, mem_data_i;
    logic [1:0][4:0]   reg_addr_i;
    logic [1:0]        mem_wrt_i;
    logic              out_valid_o, out_ready_i, out_mem_wrt_o, out_reg_wr_o, overflow_o;
    logic [31:0]       out_seq_o, out_pc_o, out_instr_o, out_reg_data_o, out_mem_addr_o, out_mem_data_o;
    logic [4:0]        out_reg_addr_o;
    logic [3:0]        count_o;
    logic [15:0]       drop_cnt_o;
`ifdef COMMIT_TRACE_PC_CHECK_EN
    logic              pc_err_o;
    logic [31:0]       err_pc_o;
`endif

    int nVec = 0;
    int nErr = 0;

    always #5 clk = ~clk;

    commit_trace_serializer dut (
        .clk(clk), .rst(rst), .update_i(update_i), .pc_i(pc_i), .instr_i(instr_i),
        .reg_addr_i(reg_addr_i), .reg_data_i(reg_data_i), .mem_addr_i(mem_addr_i),
        .mem_data_i(mem_data_i), .mem_wrt_i(mem_wrt_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_seq_o(out_seq_o), .out_pc_o(out_pc_o),
        .out_instr_o(out_instr_o), .out_reg_addr_o(out_reg_addr_o),
        .out_reg_data_o(out_reg_data_o), .out_mem_addr_o(out_mem_addr_o),
        .out_mem_data_o(out_mem_data_o), .out_mem_wrt_o(out_mem_wrt_o),
        .out_reg_wr_o(out_reg_wr_o), .count_o(count_o), .overflow_o(overflow_o),
`ifdef COMMIT_TRACE_PC_CHECK_EN
        .pc_err_o(pc_err_o), .err_pc_o(err_pc_o),
`endif
        .drop_cnt_o(drop_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; update_i = '0; out_ready_i = 1'b0; mem_wrt_i = '0;
        pc_i = '0; instr_i = {32'h13, 32'h13}; reg_addr_i = '0; reg_data_i = '0;
        mem_addr_i = '0; mem_data_i = '0;
        #12;
        chk("rst_count", count_o, 0);
        chk("rst_valid", out_valid_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_drop", drop_cnt_o, 0);
        chk("rst_pc", out_pc_o, 0);
        rst = 1'b0;

        // dual retire, drained at once
        update_i = 2'b11; pc_i = {32'h80000004, 32'h80000000}; reg_addr_i = {5'd2, 5'd1};
        mem_wrt_i = 2'b01; out_ready_i = 1'b1;
        tick(); update_i = '0;
        chk("d_count", count_o, 2);
        chk("d_pc0", out_pc_o, 32'h80000000);
        chk("d_seq0", out_seq_o, 0);
        chk("d_mwrt0", out_mem_wrt_o, 1);
        tick();
        chk("d_pc1", out_pc_o, 32'h80000004);
        chk("d_seq1", out_seq_o, 1);
        tick();
        chk("d_empty", out_valid_o, 0);
        chk("d_emptypc", out_pc_o, 0);
        tick();
        chk("d_rdyempty", count_o, 0);

        // lane-1-only retire
        out_ready_i = 1'b0; update_i = 2'b10; pc_i[1] = 32'h80000010;
        tick(); update_i = '0;
        chk("l1_count", count_o, 1);
        chk("l1_seq", out_seq_o, 2);
        chk("l1_pc", out_pc_o, 32'h80000010);
        out_ready_i = 1'b1; tick();
        chk("l1_drain", count_o, 0);

        // reg_wr derived from reg_addr
        out_ready_i = 1'b0; update_i = 2'b11; reg_addr_i = {5'd5, 5'd0};
        reg_data_i = {32'h5678, 32'h1234};
        tick(); update_i = '0;
        chk("rw_wr0", out_reg_wr_o, 0);
        chk("rw_data0", out_reg_data_o, 32'h1234);
        chk("rw_seq0", out_seq_o, 3);
        out_ready_i = 1'b1; tick();
        chk("rw_wr1", out_reg_wr_o, 1);
        chk("rw_addr1", out_reg_addr_o, 5);
        tick();
        chk("rw_drain", count_o, 0);

        // fill to DEPTH (pointers wrap), then overflow
        out_ready_i = 1'b0; update_i = 2'b11;
        for (int i = 0; i < 4; i++) tick();
        chk("f_count", count_o, 8);
        chk("f_ovf", overflow_o, 0);
        chk("f_head", out_seq_o, 5);
        tick();
        chk("o_count", count_o, 8);
        chk("o_drop", drop_cnt_o, 2);
        chk("o_ovf", overflow_o, 1);
        update_i = '0; out_ready_i = 1'b1; tick();
        chk("p_count", count_o, 7);
        update_i = 2'b11; tick(); update_i = '0;
        chk("pp_count", count_o, 7);
        chk("pp_drop", drop_cnt_o, 3);
        chk("pp_head", out_seq_o, 7);
        tick(); tick();
        chk("m_count", count_o, 5);
        chk("m_head", out_seq_o, 9);

        // async reset mid-stream
        out_ready_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("ar_count", count_o, 0);
        chk("ar_valid", out_valid_o, 0);
        chk("ar_ovf", overflow_o, 0);
        chk("ar_drop", drop_cnt_o, 0);
        #2 rst = 1'b0;
        update_i = 2'b01; pc_i[0] = 32'h80000000;
        tick(); update_i = '0;
        chk("ar_seq", out_seq_o, 0);
        chk("ar_cnt1", count_o, 1);

`ifdef COMMIT_TRACE_PC_CHECK_EN
        #2 rst = 1'b1; #2 rst = 1'b0;
        update_i = 2'b11; pc_i = {32'h80000008, 32'h80000000}; instr_i = {32'h13, 32'h13};
        tick(); update_i = '0;
        chk("pc_err", pc_err_o, 1);
        chk("pc_errpc", err_pc_o, 32'h80000008);
        #2 rst = 1'b1; #2 rst = 1'b0;
        update_i = 2'b11; pc_i = {32'h80000100, 32'h80000000}; instr_i = {32'h13, 32'h6f};
        tick(); update_i = '0;
        chk("pc_jal", pc_err_o, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
